// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared constants and helpers for the interrupt acknowledge sequencer:
// FSM state codes, level count and 8-bit rotate / priority-scan helpers.
package pic_pkg;

    localparam int LEVELS = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_ACK1    = 2'd2;
    localparam logic [1:0] ST_ACK2    = 2'd3;

    // Rotate right: bit 'amount' of the input ends up at bit 0.
    function automatic logic [7:0] rotr8(input logic [7:0] value, input logic [2:0] amount);
        logic [15:0] both;
        both = {value, value} >> amount;
        return both[7:0];
    endfunction

    // Rotate left: bit 0 of the input ends up at bit 'amount'.
    function automatic logic [7:0] rotl8(input logic [7:0] value, input logic [2:0] amount);
        logic [15:0] both;
        both = {value, value} << amount;
        return both[15:8];
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [2:0] first_one8(input logic [7:0] value);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (value[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_priority_resolver.sv
// Combinational priority resolver: finds the highest-priority pending request
// and the highest-priority in-service level under the current rotation, and
// decides whether the request may interrupt the CPU.
module priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] interrupt_request,
    input  logic [7:0] in_service_register,
    input  logic [2:0] priority_rotate,
    output logic       cand_valid,
    output logic [2:0] cand_level,
    output logic       isr_valid,
    output logic [2:0] isr_top,
    output logic       qualify
);

    logic [2:0] shift_s;
    logic [7:0] req_rot_s;
    logic [7:0] isr_rot_s;
    logic [2:0] cand_rank_s;
    logic [2:0] isr_rank_s;

    // Rotate so the highest-priority level sits at bit 0, scan, then map back.
    always_comb begin
        shift_s     = priority_rotate + 3'd1;
        req_rot_s   = rotr8(interrupt_request, shift_s);
        isr_rot_s   = rotr8(in_service_register, shift_s);
        cand_rank_s = first_one8(req_rot_s);
        isr_rank_s  = first_one8(isr_rot_s);
        cand_level  = cand_rank_s + shift_s;
        isr_top     = isr_rank_s + shift_s;
        cand_valid  = |interrupt_request;
        isr_valid   = |in_service_register;
        if (!cand_valid) begin
            qualify = 1'b0;
        end else if (!isr_valid) begin
            qualify = 1'b1;
        end else begin
            qualify = (cand_rank_s < isr_rank_s);
        end
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Interrupt acknowledge sequencer: raises INT for a qualifying request, runs
// the two-pulse INTA handshake (ISR set strobe, then vector), and turns EOI
// commands and automatic EOI into ISR clear masks and rotation updates.
module interrupt_ack_sequencer
    import pic_pkg::*;
#(
    parameter int NUM_LEVELS = 8,
    parameter int VEC_LSB_W  = 3
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [NUM_LEVELS-1:0]             interrupt_request,
    input  logic [NUM_LEVELS-1:0]             in_service_register,
    input  logic [VEC_LSB_W-1:0]              priority_rotate,
    input  logic                              inta_strobe,
    input  logic                              eoi_command,
    input  logic                              eoi_specific,
    input  logic [VEC_LSB_W-1:0]              eoi_level,
    input  logic                              rotate_on_eoi,
    input  logic                              auto_eoi_mode,
    input  logic [NUM_LEVELS-VEC_LSB_W-1:0]   vector_base,
    output logic                              interrupt_to_cpu,
    output logic                              latch_in_service,
    output logic [NUM_LEVELS-1:0]             interrupt,
    output logic [NUM_LEVELS-1:0]             clear_request,
    output logic [NUM_LEVELS-1:0]             end_of_interrupt,
    output logic                              rotate_load,
    output logic [VEC_LSB_W-1:0]              rotate_value,
    output logic [NUM_LEVELS-1:0]             vector_out,
    output logic                              vector_valid
);

    logic [1:0]           state_r;
    logic [1:0]           next_state_s;
    logic [VEC_LSB_W-1:0] level_r;
    logic                 spurious_r;

    logic                 cand_valid_s;
    logic [2:0]           cand_level_s;
    logic                 isr_valid_s;
    logic [2:0]           isr_top_s;
    logic                 qualify_s;

    logic                 ack1_entry_s;
    logic                 ack2_fire_s;
    logic [7:0]           set_mask_s;
    logic [2:0]           eoi_target_s;
    logic                 eoi_hit_s;
    logic                 rotate_hit_s;
    logic [7:0]           eoi_mask_s;
    logic [7:0]           aeoi_mask_s;

    priority_resolver u_resolver (
        .interrupt_request   (interrupt_request),
        .in_service_register (in_service_register),
        .priority_rotate     (priority_rotate),
        .cand_valid          (cand_valid_s),
        .cand_level          (cand_level_s),
        .isr_valid           (isr_valid_s),
        .isr_top             (isr_top_s),
        .qualify             (qualify_s)
    );

    // Next-state decode; INTA in IDLE and ACK1 has no effect.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (qualify_s) begin
                    next_state_s = ST_PENDING;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (inta_strobe) begin
                    next_state_s = ST_ACK1;
                end else if (!qualify_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_PENDING;
                end
            end
            ST_ACK1: begin
                next_state_s = ST_ACK2;
            end
            ST_ACK2: begin
                if (inta_strobe) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_ACK2;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Handshake strobes and EOI/AEOI clear masks for the next cycle.
    always_comb begin
        ack1_entry_s = (state_r == ST_PENDING) && inta_strobe;
        ack2_fire_s  = (state_r == ST_ACK2) && inta_strobe;
        if (ack1_entry_s && cand_valid_s) begin
            set_mask_s = onehot8(cand_level_s);
        end else begin
            set_mask_s = 8'h00;
        end
        if (eoi_specific) begin
            eoi_target_s = eoi_level;
        end else begin
            eoi_target_s = isr_top_s;
        end
        // A non-specific EOI with nothing in service has no target at all.
        eoi_hit_s    = eoi_command && (eoi_specific || isr_valid_s);
        rotate_hit_s = eoi_hit_s && rotate_on_eoi;
        if (eoi_hit_s) begin
            eoi_mask_s = onehot8(eoi_target_s);
        end else begin
            eoi_mask_s = 8'h00;
        end
        if (ack2_fire_s && auto_eoi_mode && !spurious_r) begin
            aeoi_mask_s = onehot8(level_r);
        end else begin
            aeoi_mask_s = 8'h00;
        end
    end

    // Sequencer state, latched level and all registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            level_r          <= 3'd0;
            spurious_r       <= 1'b0;
            interrupt_to_cpu <= 1'b0;
            latch_in_service <= 1'b0;
            interrupt        <= 8'h00;
            clear_request    <= 8'h00;
            end_of_interrupt <= 8'h00;
            rotate_load      <= 1'b0;
            rotate_value     <= 3'd0;
            vector_out       <= 8'h00;
            vector_valid     <= 1'b0;
        end else begin
            state_r          <= next_state_s;
            interrupt_to_cpu <= (state_r == ST_PENDING) && (next_state_s == ST_PENDING);
            if (ack1_entry_s) begin
                level_r    <= cand_valid_s ? cand_level_s : 3'd7;
                spurious_r <= !cand_valid_s;
            end
            latch_in_service <= ack1_entry_s && cand_valid_s;
            interrupt        <= set_mask_s;
            clear_request    <= set_mask_s;
            vector_valid     <= ack2_fire_s;
            vector_out       <= ack2_fire_s ? {vector_base, level_r} : 8'h00;
            end_of_interrupt <= eoi_mask_s | aeoi_mask_s;
            rotate_load      <= rotate_hit_s;
            if (rotate_hit_s) begin
                rotate_value <= eoi_target_s;
            end
        end
    end

endmodule

// File: doc/interrupt_ack_sequencer.md
Name: interrupt_ack_sequencer

Overview:
- Control-side sequencer for the in-service register block. It resolves the highest-priority pending request against the current in-service bits and drives the CPU interrupt line.
- It runs the two-pulse INTA handshake. On the first pulse it produces the one-hot `interrupt` and `latch_in_service` strobes that set an in-service bit. On the second pulse it drives the 8-bit vector.
- It converts EOI commands (non-specific, specific, automatic, rotating) into the `end_of_interrupt` mask and priority-rotate updates.
- It sits between the IRR/IMR logic, the in-service register and the data-bus buffer.

Parameters:
- NUM_LEVELS, 8, number of interrupt levels; only 8 is supported.
- VEC_LSB_W, 3, vector low bits carrying the level number.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- interrupt_request  in  8  pending requests, already masked by IMR.
- in_service_register  in  8  current in-service bits from the ISR block.
- priority_rotate  in  3  current lowest-priority level.
- inta_strobe  in  1  one-cycle pulse per INTA falling edge, pre-synchronised.
- eoi_command  in  1  one-cycle EOI command strobe.
- eoi_specific  in  1  qualifies eoi_command: 1 = specific (use eoi_level), 0 = non-specific.
- eoi_level  in  3  level for a specific EOI.
- rotate_on_eoi  in  1  qualifies eoi_command: rotate priority after the EOI.
- auto_eoi_mode  in  1  AEOI mode, static configuration.
- vector_base  in  5  ICW2 T7..T3.
- interrupt_to_cpu  out  1  INT line to the CPU.
- latch_in_service  out  1  one-cycle strobe to the ISR block.
- interrupt  out  8  one-hot level to set in the ISR; valid while latch_in_service = 1.
- clear_request  out  8  one-hot clear of the acknowledged IRR bit; one cycle.
- end_of_interrupt  out  8  ISR bits to clear; one-cycle pulse.
- rotate_load  out  1  one-cycle load strobe for priority_rotate.
- rotate_value  out  3  new lowest-priority level.
- vector_out  out  8  vector {vector_base, level}.
- vector_valid  out  1  vector_out valid; data-bus enable.

Behaviour:
- Priority order:
  - Highest priority is level (priority_rotate+1) mod 8, descending cyclically; priority_rotate itself is lowest.
  - cand = the highest-priority bit of interrupt_request.
  - isr_top = the highest-priority bit of in_service_register.
  - A request qualifies only if cand ranks strictly above isr_top, or the ISR is empty.
- FSM states: IDLE, PENDING, ACK1, ACK2; encoding lives in the package.
- IDLE -> PENDING when a qualifying request exists.
  - interrupt_to_cpu is registered: it goes high on the cycle after entry to PENDING.
- PENDING:
  - If the qualifying request vanishes before inta_strobe, return to IDLE and deassert interrupt_to_cpu.
  - On inta_strobe, latch level L = cand. If no request remains in that cycle (spurious), L = 7 and a spurious flag is set.
  - Then go to ACK1.
- ACK1 (one cycle):
  - latch_in_service = 1; interrupt = one-hot(L); clear_request = one-hot(L).
  - If spurious, all three are 0.
  - interrupt_to_cpu drops; wait in ACK2.
- ACK2:
  - On inta_strobe: vector_out = {vector_base, L}; vector_valid = 1 for exactly one cycle.
  - If auto_eoi_mode and not spurious, end_of_interrupt = one-hot(L) in that same cycle.
  - Return to IDLE.
- Reset mid-sequence returns to IDLE with all outputs cleared; no vector is driven.
- EOI handling (any state):
  - On eoi_command, the target is eoi_level if eoi_specific, else isr_top.
  - end_of_interrupt = one-hot(target) on the next cycle. A non-specific EOI with an empty ISR produces an all-zero mask.
  - If rotate_on_eoi, rotate_load = 1 and rotate_value = target in the same cycle.
- Simultaneous events:
  - An EOI and an AEOI in the same cycle are OR-ed into end_of_interrupt.
  - An EOI during PENDING forces re-evaluation of qualification on the next cycle.
  - inta_strobe in IDLE is ignored.
  - inta_strobe in ACK1 is ignored.
- Reset values: all outputs 0; state IDLE; L = 0.
- Latency:
  - request -> interrupt_to_cpu: 2 cycles.
  - inta_strobe -> latch_in_service: 1 cycle.
  - 2nd inta_strobe -> vector_valid: 1 cycle.

Decomposition:
- Package pic_pkg:
  - FSM state enum.
  - LEVELS=8 constant.
  - Function rotl8/rotr8.
  - Function first_one8 (index of lowest set bit).
- Sub-module priority_resolver: rotates the request and ISR vectors by priority_rotate+1, finds the first set bit of each, rotates the index back, and compares the two. Purely combinational; instantiated once.
- FSM and EOI logic live in the top module.

Test Plan:
1. Reset, ISR=0, rotate=7, request=8'h24 -> interrupt_to_cpu high 2 cycles later. Two inta_strobe pulses -> interrupt=8'h04, latch_in_service pulse, vector_out={vector_base=5'h08, 3'd2}=8'h42, vector_valid one cycle.
2. ISR=8'h02, request=8'h08, rotate=7 -> interrupt_to_cpu stays 0 (level 3 is lower priority). Non-specific EOI -> end_of_interrupt=8'h02, after which the request qualifies and INT rises.
3. rotate=3, request=8'h11 -> level 4 is selected. Specific EOI level 4 with rotate_on_eoi -> end_of_interrupt=8'h10, rotate_load=1, rotate_value=4.
4. auto_eoi_mode=1, request=8'h80 -> ACK1 interrupt=8'h80. Second INTA cycle -> vector_valid=1 and end_of_interrupt=8'h80 in the same cycle.
5. Request drops to 0 between INT and the first inta_strobe, arriving in the same cycle -> spurious: interrupt=0, latch_in_service=0, vector_out low bits = 7.
6. reset_n low during ACK2 -> next cycle state IDLE, all outputs 0. A subsequent inta_strobe produces no vector_valid.
